// File: rtl/nmr_pkg.sv
// rtl/nmr_pkg.sv - shared types and widths for the N-modular-redundancy vote manager
package nmr_pkg;

    typedef enum logic [1:0] {
        ST_ACTIVE      = 2'd0,
        ST_SUSPECT     = 2'd1,
        ST_QUARANTINED = 2'd2
    } rep_state_t;

    localparam int FLAG_W     = 3;
    localparam int FAULT_W    = 16;
    localparam int MIN_ACTIVE = 3;

endpackage

// File: rtl/nmr_replica_tracker.sv
// rtl/nmr_replica_tracker.sv - per-replica health FSM with consecutive-miscompare counter
module nmr_replica_tracker
    import nmr_pkg::*;
#(
    parameter int FAULT_THRESH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vote_en,
    input  logic       agree,
    input  logic       grant,
    input  logic       clear,
    output logic       quarantine_req,
    output rep_state_t state
);

    localparam int CW = $clog2(FAULT_THRESH + 1);
    localparam logic [CW-1:0] THRESH_C = CW'(FAULT_THRESH);

    logic [CW-1:0] count;
    logic [CW-1:0] count_inc;

    // Count saturates at the threshold so a floor-blocked replica keeps asking.
    assign count_inc      = (count == THRESH_C) ? THRESH_C : count + CW'(1);
    assign quarantine_req = vote_en && !agree && (count_inc == THRESH_C);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_ACTIVE;
            count <= '0;
        end else if (clear) begin
            state <= ST_ACTIVE;
            count <= '0;
        end else if (vote_en) begin
            if (agree) begin
                state <= ST_ACTIVE;
                count <= '0;
            end else if (quarantine_req && grant) begin
                state <= ST_QUARANTINED;
                count <= count_inc;
            end else begin
                state <= ST_SUSPECT;
                count <= count_inc;
            end
        end
    end

endmodule

// File: rtl/nmr_vote_manager.sv
// rtl/nmr_vote_manager.sv - majority voter over NR replica results with replica quarantine
module nmr_vote_manager
    import nmr_pkg::*;
#(
    parameter int N            = 64,
    parameter int NR           = 5,
    parameter int FAULT_THRESH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NR-1:0][N-1:0]         rep_result,
    input  logic [NR-1:0][FLAG_W-1:0]    rep_flags,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [N-1:0]                 out_result,
    output logic [FLAG_W-1:0]            out_flags,
    output logic                         no_majority,
    input  logic [NR-1:0]                clear_quarantine,
    output logic [NR-1:0][1:0]           rep_state,
    output logic [FAULT_W-1:0]           fault_total
);

    if ((NR % 2) == 0 || NR < 3 || NR > 7) begin : g_bad_nr
        $error("nmr_vote_manager: NR must be odd and within 3..7");
    end

    localparam int CNT_W = $clog2(NR + 1);
    localparam int IDX_W = $clog2(NR);

    rep_state_t         st [NR];
    logic [NR-1:0]      active;
    logic [NR-1:0]      agree;
    logic [NR-1:0]      vote_en;
    logic [NR-1:0]      qreq;
    logic [NR-1:0]      grant;
    logic [CNT_W-1:0]   active_cnt;
    logic [CNT_W-1:0]   votes_i;
    logic [CNT_W-1:0]   budget;
    logic [CNT_W-1:0]   used;
    logic               found;
    logic               have_first;
    logic [IDX_W-1:0]   first;
    logic [IDX_W-1:0]   win;
    logic [N-1:0]       sel_result;
    logic [FLAG_W-1:0]  sel_flags;
    logic               any_dissent;
    logic               accept;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    for (genvar g = 0; g < NR; g++) begin : g_rep
        assign active[g]    = (st[g] != ST_QUARANTINED);
        assign agree[g]     = (rep_result[g] == sel_result) && (rep_flags[g] == sel_flags);
        assign vote_en[g]   = accept && found && active[g];
        assign rep_state[g] = st[g];

        nmr_replica_tracker #(.FAULT_THRESH(FAULT_THRESH)) u_trk (
            .clk            (clk),
            .reset          (reset),
            .vote_en        (vote_en[g]),
            .agree          (agree[g]),
            .grant          (grant[g]),
            .clear          (clear_quarantine[g]),
            .quarantine_req (qreq[g]),
            .state          (st[g])
        );
    end

    // Majority winner is the lowest-index active replica whose value has > active/2 matches.
    always_comb begin
        active_cnt = '0;
        for (int i = 0; i < NR; i++) begin
            active_cnt = active_cnt + CNT_W'(active[i]);
        end
        found      = 1'b0;
        win        = '0;
        have_first = 1'b0;
        first      = '0;
        votes_i    = '0;
        for (int i = 0; i < NR; i++) begin
            votes_i = '0;
            for (int j = 0; j < NR; j++) begin
                if (active[j] && rep_result[j] == rep_result[i] && rep_flags[j] == rep_flags[i]) begin
                    votes_i = votes_i + CNT_W'(1);
                end
            end
            if (active[i] && !have_first) begin
                have_first = 1'b1;
                first      = IDX_W'(i);
            end
            if (active[i] && !found && ({votes_i, 1'b0} > {1'b0, active_cnt})) begin
                found = 1'b1;
                win   = IDX_W'(i);
            end
        end
        if (!found) begin
            win = first;
        end
        sel_result  = rep_result[win];
        sel_flags   = rep_flags[win];
        any_dissent = |(active & ~agree);
    end

    // Only as many quarantines as keep MIN_ACTIVE replicas voting; low indices go first.
    always_comb begin
        budget = (active_cnt > CNT_W'(MIN_ACTIVE)) ? active_cnt - CNT_W'(MIN_ACTIVE) : '0;
        used   = '0;
        grant  = '0;
        for (int i = 0; i < NR; i++) begin
            if (qreq[i] && used < budget) begin
                grant[i] = 1'b1;
                used     = used + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_flags   <= '0;
            no_majority <= 1'b0;
            fault_total <= '0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_result  <= sel_result;
            out_flags   <= sel_flags;
            no_majority <= !found;
            if (any_dissent && fault_total != {FAULT_W{1'b1}}) begin
                fault_total <= fault_total + FAULT_W'(1);
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
